// File: rtl/ysyx_25030093_pkg.sv
// ysyx_25030093_pkg
// Shared definitions for the multi-cycle RV32 core control path:
//   - state_e        : sequencer state encodings, also exported on state_dbg
//   - PC_SEL_*       : next-PC select codes, shared by the sequencer, PC unit
//                      and decoder
//   - pc_sel_decode  : priority encoder that maps control-flow flags to PC_SEL_*
package ysyx_25030093_pkg;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_IWAIT = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MREQ  = 3'd3,
    ST_MWAIT = 3'd4,
    ST_WB    = 3'd5,
    ST_HALT  = 3'd6,
    ST_ERROR = 3'd7
  } state_e;

  localparam logic [2:0] PC_SEL_SNPC = 3'b000;
  localparam logic [2:0] PC_SEL_JALR = 3'b001;
  localparam logic [2:0] PC_SEL_JAL  = 3'b010;
  localparam logic [2:0] PC_SEL_BR   = 3'b100;
  localparam logic [2:0] PC_SEL_CSR  = 3'b101;

  // Trap redirection wins over every other control-flow source, then jalr,
  // jal and finally branch; anything else falls through to PC+4.
  function automatic logic [2:0] pc_sel_decode(input logic trap,
                                               input logic jalr,
                                               input logic jal,
                                               input logic branch);
    if (trap)        return PC_SEL_CSR;
    else if (jalr)   return PC_SEL_JALR;
    else if (jal)    return PC_SEL_JAL;
    else if (branch) return PC_SEL_BR;
    else             return PC_SEL_SNPC;
  endfunction

endpackage

// File: rtl/ysyx_25030093_timeout_cnt.sv
// ysyx_25030093_timeout_cnt
// Counts consecutive cycles spent waiting on a memory handshake.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   en        : the awaited ready/valid is still low this cycle
//   clr       : restart the count (takes priority over en)
//   expire    : the count has reached TIMEOUT-1; if en is still high in this
//               cycle the wait has lasted TIMEOUT cycles
module ysyx_25030093_timeout_cnt #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int unsigned   CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Decoded from the register only, so the sequencer's next-state logic can
  // use it without forming a combinational loop through clr.
  assign expire = (cnt == LIMIT);

endmodule

// File: rtl/ysyx_25030093_core_seq.sv
// ysyx_25030093_core_seq
// Multi-cycle control sequencer: FETCH -> IWAIT -> EXEC -> (MREQ -> MWAIT) -> WB.
// Owns the imem/dmem valid/ready handshakes, gates PC and register-file writes,
// selects the next-PC source, counts retired instructions and traps memory
// timeouts into an absorbing ERROR state.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   imem_req_valid/ready              : fetch request handshake
//   imem_resp_valid, ir_we            : instruction response / IR load strobe
//   dec_*                             : decoder flags, stable from EXEC to WB
//   dmem_req_valid/ready              : data request handshake
//   dmem_resp_valid                   : load data / store ack
//   rf_we_en, pc_we, pc_sel           : writeback strobes and next-PC select
//   instret                           : retired-instruction counter
//   halt, err, state_dbg              : status and debug state
module ysyx_25030093_core_seq #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  input  logic             imem_resp_valid,
  output logic             ir_we,
  input  logic             dec_load,
  input  logic             dec_store,
  input  logic             dec_jal,
  input  logic             dec_jalr,
  input  logic             dec_branch,
  input  logic             dec_trap,
  input  logic             dec_ebreak,
  output logic             dmem_req_valid,
  input  logic             dmem_req_ready,
  input  logic             dmem_resp_valid,
  output logic             rf_we_en,
  output logic             pc_we,
  output logic [2:0]       pc_sel,
  output logic [CNT_W-1:0] instret,
  output logic             halt,
  output logic             err,
  output logic [2:0]       state_dbg
);

  import ysyx_25030093_pkg::*;

  state_e state, state_nxt;
  logic   tmo_en, tmo_clr, tmo_expire;

  // The wait condition per state: high while the awaited ready/valid is low.
  // NOTE: every variable written in an always_comb gets a default first, so
  // no path through the case can leave it unassigned and infer a latch.
  always_comb begin
    tmo_en = 1'b0;
    case (state)
      ST_FETCH: tmo_en = !imem_req_ready;
      ST_IWAIT: tmo_en = !imem_resp_valid;
      ST_MREQ:  tmo_en = !dmem_req_ready;
      ST_MWAIT: tmo_en = !dmem_resp_valid;
      default:  tmo_en = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      // In FETCH only the request handshake counts; a same-cycle response is
      // dropped because the request has not been accepted yet.
      ST_FETCH: if (imem_req_ready)  state_nxt = ST_IWAIT;
      ST_IWAIT: if (imem_resp_valid) state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (dec_ebreak)                  state_nxt = ST_HALT;
        else if (dec_load || dec_store)  state_nxt = ST_MREQ;
        else                             state_nxt = ST_WB;
      end
      ST_MREQ:  if (dmem_req_ready)  state_nxt = ST_MWAIT;
      ST_MWAIT: if (dmem_resp_valid) state_nxt = ST_WB;
      ST_WB:    state_nxt = ST_FETCH;
      default:  state_nxt = state;  // HALT and ERROR are absorbing
    endcase
    if (tmo_en && tmo_expire) state_nxt = ST_ERROR;
  end

  // The count restarts on every state change and whenever nothing is awaited.
  assign tmo_clr = (state_nxt != state) || !tmo_en;

  ysyx_25030093_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst    (rst),
    .en     (tmo_en),
    .clr    (tmo_clr),
    .expire (tmo_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_FETCH;
      instret <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_WB) instret <= instret + CNT_W'(1);
    end
  end

  // Strobes are decoded from the state register (ir_we also qualifies on the
  // response) and are forced low while rst is high, so no handshake or write
  // is ever issued in a reset cycle.
  assign imem_req_valid = !rst && (state == ST_FETCH);
  assign ir_we          = !rst && (state == ST_IWAIT) && imem_resp_valid;
  assign dmem_req_valid = !rst && (state == ST_MREQ);
  assign pc_we          = !rst && (state == ST_WB);
  assign rf_we_en       = pc_we && !(dec_store || dec_branch || dec_trap);
  assign pc_sel         = pc_we ? pc_sel_decode(dec_trap, dec_jalr, dec_jal, dec_branch)
                                : PC_SEL_SNPC;

  assign halt      = (state == ST_HALT);
  assign err       = (state == ST_ERROR);
  assign state_dbg = state;

endmodule

// File: tb/tb_ysyx_25030093_core_seq.sv
// tb_ysyx_25030093_core_seq
// Table-driven bench for the core sequencer: each table row gives the inputs
// for one clock cycle and the outputs expected in that cycle. Timeout and
// reset-in-flight corners are exercised as hand-written sequences.
module tb_ysyx_25030093_core_seq;

  localparam int unsigned TMO = 8;

  // Decoder flag bundle {load, store, jal, jalr, branch, trap, ebreak}
  localparam logic [6:0] D_NONE  = 7'b0000000;
  localparam logic [6:0] D_LOAD  = 7'b1000000;
  localparam logic [6:0] D_STORE = 7'b0100000;
  localparam logic [6:0] D_JAL   = 7'b0010000;
  localparam logic [6:0] D_JALR  = 7'b0001000;
  localparam logic [6:0] D_BR    = 7'b0000100;
  localparam logic [6:0] D_TRAP  = 7'b0000010;
  localparam logic [6:0] D_EBRK  = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid, ir_we;
  logic        dec_load, dec_store, dec_jal, dec_jalr, dec_branch, dec_trap, dec_ebreak;
  logic        dmem_req_valid, dmem_req_ready, dmem_resp_valid;
  logic        rf_we_en, pc_we, halt, err;
  logic [2:0]  pc_sel, state_dbg;
  logic [63:0] instret;

  ysyx_25030093_core_seq #(
    .TIMEOUT (TMO),
    .CNT_W   (64)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .ir_we           (ir_we),
    .dec_load        (dec_load),
    .dec_store       (dec_store),
    .dec_jal         (dec_jal),
    .dec_jalr        (dec_jalr),
    .dec_branch      (dec_branch),
    .dec_trap        (dec_trap),
    .dec_ebreak      (dec_ebreak),
    .dmem_req_valid  (dmem_req_valid),
    .dmem_req_ready  (dmem_req_ready),
    .dmem_resp_valid (dmem_resp_valid),
    .rf_we_en        (rf_we_en),
    .pc_we           (pc_we),
    .pc_sel          (pc_sel),
    .instret         (instret),
    .halt            (halt),
    .err             (err),
    .state_dbg       (state_dbg)
  );

  always #5 clk = ~clk;

  // Observed outputs: {state, imem_req, ir_we, dmem_req, pc_we, rf_we, pc_sel,
  //                    halt, err, instret[15:0]}
  logic [28:0] obs;
  assign obs = {state_dbg, imem_req_valid, ir_we, dmem_req_valid, pc_we, rf_we_en,
                pc_sel, halt, err, instret[15:0]};

  typedef struct packed {
    logic        rst;
    logic [3:0]  mem;   // {imem_req_ready, imem_resp_valid, dmem_req_ready, dmem_resp_valid}
    logic [6:0]  dec;
    logic [28:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic r, input logic [3:0] mem, input logic [6:0] dec,
                              input logic [2:0] st, input logic [4:0] strb,
                              input logic [2:0] sel, input logic [1:0] he,
                              input logic [15:0] ir);
    vec_t v;
    v.rst = r;
    v.mem = mem;
    v.dec = dec;
    v.exp = {st, strb, sel, he, ir};
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic [3:0] mem, input logic [6:0] dec);
    rst = r;
    {imem_req_ready, imem_resp_valid, dmem_req_ready, dmem_resp_valid} = mem;
    {dec_load, dec_store, dec_jal, dec_jalr, dec_branch, dec_trap, dec_ebreak} = dec;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    apply(1'b1, 4'b0000, D_NONE);
    step();
    apply(1'b0, 4'b0000, D_NONE);
  endtask

  initial begin
    apply(1'b1, 4'b0000, D_NONE);
    step();
    step();

    // Reset cycle: FETCH, all strobes gated off, counter clear
    tbl.push_back(mk(1, 4'b0000, D_NONE, 3'd0, 5'b00000, 3'b000, 2'b00, 16'd0));
    // add, zero-wait memories (ready and resp both high in FETCH: only ready counts)
    tbl.push_back(mk(0, 4'b1111, D_NONE, 3'd0, 5'b10000, 3'b000, 2'b00, 16'd0));
    tbl.push_back(mk(0, 4'b1111, D_NONE, 3'd1, 5'b01000, 3'b000, 2'b00, 16'd0));
    tbl.push_back(mk(0, 4'b1111, D_NONE, 3'd2, 5'b00000, 3'b000, 2'b00, 16'd0));
    tbl.push_back(mk(0, 4'b1111, D_NONE, 3'd5, 5'b00011, 3'b000, 2'b00, 16'd0));
    // load: dmem ready after 3 wait cycles, response 2 cycles after that
    tbl.push_back(mk(0, 4'b1000, D_LOAD, 3'd0, 5'b10000, 3'b000, 2'b00, 16'd1));
    tbl.push_back(mk(0, 4'b0100, D_LOAD, 3'd1, 5'b01000, 3'b000, 2'b00, 16'd1));
    tbl.push_back(mk(0, 4'b0000, D_LOAD, 3'd2, 5'b00000, 3'b000, 2'b00, 16'd1));
    tbl.push_back(mk(0, 4'b0001, D_LOAD, 3'd3, 5'b00100, 3'b000, 2'b00, 16'd1));
    tbl.push_back(mk(0, 4'b0000, D_LOAD, 3'd3, 5'b00100, 3'b000, 2'b00, 16'd1));
    tbl.push_back(mk(0, 4'b0000, D_LOAD, 3'd3, 5'b00100, 3'b000, 2'b00, 16'd1));
    tbl.push_back(mk(0, 4'b0010, D_LOAD, 3'd3, 5'b00100, 3'b000, 2'b00, 16'd1));
    tbl.push_back(mk(0, 4'b0000, D_LOAD, 3'd4, 5'b00000, 3'b000, 2'b00, 16'd1));
    tbl.push_back(mk(0, 4'b0001, D_LOAD, 3'd4, 5'b00000, 3'b000, 2'b00, 16'd1));
    tbl.push_back(mk(0, 4'b0000, D_LOAD, 3'd5, 5'b00011, 3'b000, 2'b00, 16'd1));
    // store, zero-wait: no register write
    tbl.push_back(mk(0, 4'b1111, D_STORE, 3'd0, 5'b10000, 3'b000, 2'b00, 16'd2));
    tbl.push_back(mk(0, 4'b1111, D_STORE, 3'd1, 5'b01000, 3'b000, 2'b00, 16'd2));
    tbl.push_back(mk(0, 4'b1111, D_STORE, 3'd2, 5'b00000, 3'b000, 2'b00, 16'd2));
    tbl.push_back(mk(0, 4'b1111, D_STORE, 3'd3, 5'b00100, 3'b000, 2'b00, 16'd2));
    tbl.push_back(mk(0, 4'b1111, D_STORE, 3'd4, 5'b00000, 3'b000, 2'b00, 16'd2));
    tbl.push_back(mk(0, 4'b1111, D_STORE, 3'd5, 5'b00010, 3'b000, 2'b00, 16'd2));
    // jalr
    tbl.push_back(mk(0, 4'b1111, D_JALR, 3'd0, 5'b10000, 3'b000, 2'b00, 16'd3));
    tbl.push_back(mk(0, 4'b1111, D_JALR, 3'd1, 5'b01000, 3'b000, 2'b00, 16'd3));
    tbl.push_back(mk(0, 4'b1111, D_JALR, 3'd2, 5'b00000, 3'b000, 2'b00, 16'd3));
    tbl.push_back(mk(0, 4'b1111, D_JALR, 3'd5, 5'b00011, 3'b001, 2'b00, 16'd3));
    // branch: no register write
    tbl.push_back(mk(0, 4'b1111, D_BR, 3'd0, 5'b10000, 3'b000, 2'b00, 16'd4));
    tbl.push_back(mk(0, 4'b1111, D_BR, 3'd1, 5'b01000, 3'b000, 2'b00, 16'd4));
    tbl.push_back(mk(0, 4'b1111, D_BR, 3'd2, 5'b00000, 3'b000, 2'b00, 16'd4));
    tbl.push_back(mk(0, 4'b1111, D_BR, 3'd5, 5'b00010, 3'b100, 2'b00, 16'd4));
    // jal
    tbl.push_back(mk(0, 4'b1111, D_JAL, 3'd0, 5'b10000, 3'b000, 2'b00, 16'd5));
    tbl.push_back(mk(0, 4'b1111, D_JAL, 3'd1, 5'b01000, 3'b000, 2'b00, 16'd5));
    tbl.push_back(mk(0, 4'b1111, D_JAL, 3'd2, 5'b00000, 3'b000, 2'b00, 16'd5));
    tbl.push_back(mk(0, 4'b1111, D_JAL, 3'd5, 5'b00011, 3'b010, 2'b00, 16'd5));
    // trap + jalr: trap select wins, no register write
    tbl.push_back(mk(0, 4'b1111, D_TRAP | D_JALR, 3'd0, 5'b10000, 3'b000, 2'b00, 16'd6));
    tbl.push_back(mk(0, 4'b1111, D_TRAP | D_JALR, 3'd1, 5'b01000, 3'b000, 2'b00, 16'd6));
    tbl.push_back(mk(0, 4'b1111, D_TRAP | D_JALR, 3'd2, 5'b00000, 3'b000, 2'b00, 16'd6));
    tbl.push_back(mk(0, 4'b1111, D_TRAP | D_JALR, 3'd5, 5'b00010, 3'b101, 2'b00, 16'd6));
    // jal + branch: jal select wins, branch still suppresses the register write
    tbl.push_back(mk(0, 4'b1111, D_JAL | D_BR, 3'd0, 5'b10000, 3'b000, 2'b00, 16'd7));
    tbl.push_back(mk(0, 4'b1111, D_JAL | D_BR, 3'd1, 5'b01000, 3'b000, 2'b00, 16'd7));
    tbl.push_back(mk(0, 4'b1111, D_JAL | D_BR, 3'd2, 5'b00000, 3'b000, 2'b00, 16'd7));
    tbl.push_back(mk(0, 4'b1111, D_JAL | D_BR, 3'd5, 5'b00010, 3'b010, 2'b00, 16'd7));
    // ebreak + load: HALT wins, no dmem request, responses ignored
    tbl.push_back(mk(0, 4'b1111, D_EBRK | D_LOAD, 3'd0, 5'b10000, 3'b000, 2'b00, 16'd8));
    tbl.push_back(mk(0, 4'b1111, D_EBRK | D_LOAD, 3'd1, 5'b01000, 3'b000, 2'b00, 16'd8));
    tbl.push_back(mk(0, 4'b1111, D_EBRK | D_LOAD, 3'd2, 5'b00000, 3'b000, 2'b00, 16'd8));
    tbl.push_back(mk(0, 4'b1111, D_EBRK | D_LOAD, 3'd6, 5'b00000, 3'b000, 2'b10, 16'd8));
    tbl.push_back(mk(0, 4'b0101, D_EBRK | D_LOAD, 3'd6, 5'b00000, 3'b000, 2'b10, 16'd8));
    tbl.push_back(mk(0, 4'b1111, D_NONE, 3'd6, 5'b00000, 3'b000, 2'b10, 16'd8));
    // reset out of HALT
    tbl.push_back(mk(1, 4'b0000, D_NONE, 3'd6, 5'b00000, 3'b000, 2'b10, 16'd8));
    tbl.push_back(mk(0, 4'b0000, D_NONE, 3'd0, 5'b10000, 3'b000, 2'b00, 16'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].mem, tbl[i].dec);
      check($sformatf("row%0d", i), 64'(obs), 64'(tbl[i].exp));
      step();
    end

    // Waits of TIMEOUT-1 cycles are tolerated in FETCH and IWAIT
    do_reset();
    for (int i = 0; i < int'(TMO) - 1; i++) begin
      check("fetch_wait_st", 64'(state_dbg), 64'd0);
      step();
    end
    apply(1'b0, 4'b1000, D_NONE);
    check("fetch_last_st", 64'(state_dbg), 64'd0);
    step();
    apply(1'b0, 4'b0000, D_NONE);
    for (int i = 0; i < int'(TMO) - 1; i++) begin
      check("iwait_wait_st", 64'(state_dbg), 64'd1);
      step();
    end
    apply(1'b0, 4'b0100, D_NONE);
    check("iwait_last_irwe", 64'(ir_we), 64'd1);
    step();
    apply(1'b0, 4'b0000, D_NONE);
    check("exec_st", 64'(state_dbg), 64'd2);
    step();
    check("wb_pcwe", 64'(pc_we), 64'd1);
    step();
    check("instret_one", instret, 64'd1);

    // TIMEOUT cycles without imem_req_ready: ERROR on the next cycle
    for (int i = 0; i < int'(TMO); i++) begin
      check("tmo_fetch_st", 64'(state_dbg), 64'd0);
      step();
    end
    check("tmo_err_st", 64'(state_dbg), 64'd7);
    check("tmo_err", 64'(err), 64'd1);
    check("tmo_instret", instret, 64'd1);
    apply(1'b0, 4'b1111, D_NONE);
    step();
    step();
    check("err_absorb", 64'({state_dbg, err, imem_req_valid}), 64'({3'd7, 1'b1, 1'b0}));
    apply(1'b1, 4'b0000, D_NONE);
    step();
    apply(1'b0, 4'b0000, D_NONE);
    check("err_rst", 64'({state_dbg, err, halt}), 64'({3'd0, 1'b0, 1'b0}));
    check("err_rst_instret", instret, 64'd0);

    // Reset arriving during MWAIT
    apply(1'b0, 4'b1110, D_LOAD);
    step();  // IWAIT
    step();  // EXEC
    step();  // MREQ
    check("mreq_valid", 64'(dmem_req_valid), 64'd1);
    step();  // MWAIT
    apply(1'b0, 4'b0000, D_LOAD);
    check("mwait_st", 64'(state_dbg), 64'd4);
    apply(1'b1, 4'b0001, D_LOAD);
    step();
    apply(1'b0, 4'b0000, D_NONE);
    check("mwait_rst", 64'({state_dbg, dmem_req_valid, pc_we}), 64'({3'd0, 1'b0, 1'b0}));
    check("mwait_rst_instret", instret, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
